// File: rtl/hazard_control_unit.sv
// Hazard and stall controller for the 5-stage RISC-V pipeline: load-use bubbles,
// taken-branch flushes and data-memory waits with a timeout into a sticky error state.
module hazard_control_unit #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_raddr1,
    input  logic [4:0]       id_raddr2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_waddr,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             mem_wb_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [1:0]  RUN_ST      = 2'd0;
    localparam logic [1:0]  MEM_WAIT_ST = 2'd1;
    localparam logic [1:0]  ERROR_ST    = 2'd2;
    localparam logic [15:0] TIMEOUT_C   = 16'(MEM_TIMEOUT);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [15:0]      wait_cnt_r;
    logic [15:0]      wait_cnt_nxt_s;
    logic             mem_timeout_r;
    logic             mem_timeout_nxt_s;
    logic [CNT_W-1:0] stall_count_r;
    logic             load_use_s;
    logic             pc_write_s;
    logic             if_id_write_s;
    logic             if_id_flush_s;
    logic             id_ex_write_s;
    logic             id_ex_flush_s;
    logic             ex_mem_write_s;
    logic             mem_wb_flush_s;

    // x0 never carries a real dependency, so a load targeting it cannot cause a hazard.
    function automatic logic load_use_match(
        input logic       mem_read,
        input logic [4:0] waddr,
        input logic       use1,
        input logic [4:0] raddr1,
        input logic       use2,
        input logic [4:0] raddr2
    );
        load_use_match = mem_read && (waddr != 5'd0) &&
                         ((use1 && (raddr1 == waddr)) || (use2 && (raddr2 == waddr)));
    endfunction

    assign load_use_s = load_use_match(id_ex_mem_read, id_ex_waddr, id_uses_rs1,
                                       id_raddr1, id_uses_rs2, id_raddr2);

    // Next-state and pipeline control decode; memory wait outranks branch, branch outranks load-use.
    always_comb begin
        state_nxt_s       = state_r;
        wait_cnt_nxt_s    = wait_cnt_r;
        mem_timeout_nxt_s = mem_timeout_r;
        pc_write_s        = 1'b1;
        if_id_write_s     = 1'b1;
        if_id_flush_s     = 1'b0;
        id_ex_write_s     = 1'b1;
        id_ex_flush_s     = 1'b0;
        ex_mem_write_s    = 1'b1;
        mem_wb_flush_s    = 1'b0;
        case (state_r)
            RUN_ST: begin
                wait_cnt_nxt_s = 16'd0;
                if (mem_req && !mem_ready) begin
                    pc_write_s     = 1'b0;
                    if_id_write_s  = 1'b0;
                    id_ex_write_s  = 1'b0;
                    ex_mem_write_s = 1'b0;
                    mem_wb_flush_s = 1'b1;
                    state_nxt_s    = MEM_WAIT_ST;
                    wait_cnt_nxt_s = 16'd1;
                end else if (ex_branch_taken) begin
                    if_id_flush_s = 1'b1;
                    id_ex_flush_s = 1'b1;
                end else if (load_use_s) begin
                    pc_write_s    = 1'b0;
                    if_id_write_s = 1'b0;
                    id_ex_flush_s = 1'b1;
                end else begin
                    state_nxt_s = RUN_ST;
                end
            end
            MEM_WAIT_ST: begin
                if (mem_ready) begin
                    // A branch held in EX by the freeze takes effect as the pipeline restarts.
                    if (ex_branch_taken) begin
                        if_id_flush_s = 1'b1;
                        id_ex_flush_s = 1'b1;
                    end else begin
                        if_id_flush_s = 1'b0;
                    end
                    state_nxt_s    = RUN_ST;
                    wait_cnt_nxt_s = 16'd0;
                end else begin
                    pc_write_s     = 1'b0;
                    if_id_write_s  = 1'b0;
                    id_ex_write_s  = 1'b0;
                    ex_mem_write_s = 1'b0;
                    mem_wb_flush_s = 1'b1;
                    if (wait_cnt_r == TIMEOUT_C) begin
                        state_nxt_s       = ERROR_ST;
                        mem_timeout_nxt_s = 1'b1;
                    end else begin
                        wait_cnt_nxt_s = wait_cnt_r + 16'd1;
                    end
                end
            end
            ERROR_ST: begin
                pc_write_s        = 1'b0;
                if_id_write_s     = 1'b0;
                id_ex_write_s     = 1'b0;
                ex_mem_write_s    = 1'b0;
                mem_wb_flush_s    = 1'b1;
                mem_timeout_nxt_s = 1'b1;
            end
            default: begin
                pc_write_s     = 1'b0;
                if_id_write_s  = 1'b0;
                id_ex_write_s  = 1'b0;
                ex_mem_write_s = 1'b0;
                mem_wb_flush_s = 1'b1;
                state_nxt_s    = RUN_ST;
                wait_cnt_nxt_s = 16'd0;
            end
        endcase
    end

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= RUN_ST;
            wait_cnt_r    <= 16'd0;
            mem_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            wait_cnt_r    <= wait_cnt_nxt_s;
            mem_timeout_r <= mem_timeout_nxt_s;
        end
    end

    // Saturating count of cycles in which the PC did not advance, excluding the error state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if ((state_r != ERROR_ST) && !pc_write_s &&
                     (stall_count_r != {CNT_W{1'b1}})) begin
            stall_count_r <= stall_count_r + CNT_W'(1);
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    // Controls are gated by rst_n so the pipeline is held quiet for the whole reset pulse.
    assign pc_write     = rst_n & pc_write_s;
    assign if_id_write  = rst_n & if_id_write_s;
    assign if_id_flush  = rst_n & if_id_flush_s;
    assign id_ex_write  = rst_n & id_ex_write_s;
    assign id_ex_flush  = rst_n & id_ex_flush_s;
    assign ex_mem_write = rst_n & ex_mem_write_s;
    assign mem_wb_flush = rst_n & mem_wb_flush_s;
    assign mem_timeout  = mem_timeout_r;
    assign stall_count  = stall_count_r;

endmodule
